bit_serial_adder_ctrl: RTL and testbench
========================================

# bit_serial_adder_ctrl

Multi-cycle controller that time-shares a single 1-bit full-adder cell to add or subtract two WIDTH-bit operands, one bit per clock, LSB first. Sits beside the ALU as the area-optimised add/sub path for the Antares-R2 datapath. It accepts an operation through a start/ready handshake, sequences WIDTH adder steps with a registered carry, and presents the result with a one-cycle done pulse.

## Interface
- WIDTH, 32: operand/result width in bits; legal range ≥ 2.
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only while ready=1.
- op  input  1  0 = add (a+b), 1 = subtract (a−b).
- a  input  WIDTH  first operand, captured on accepted start.
- b  input  WIDTH  second operand, captured on accepted start.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse, result valid.
- result  output  WIDTH  sum/difference; held until next accepted start.
- carry_out  output  1  final carry from MSB (subtract: 1 = no borrow).
- overflow  output  1  signed overflow flag (see Configuration).

## Operation
- States: IDLE → RUN → DONE → IDLE. Encoding 2 bits.
- IDLE: ready=1. start=1 → capture a into shift register A, op ? ~b : b into shift register B, carry register ← op, bit counter ← 0, state ← RUN.
- RUN: each cycle the cell adds A[0], B[0], carry. Sum bit shifts into result MSB (result shifts right), A and B shift right, carry ← cell Cout, counter increments. On counter = WIDTH−1, after the step, state ← DONE.
- DONE: done=1 for exactly one cycle. carry_out = final carry. State ← IDLE.
- start is ignored while busy=1. No queueing.
- result, carry_out, and overflow hold until the next accepted start. They are not cleared in IDLE.
- Arithmetic is modulo 2^WIDTH. Subtract uses two's complement: invert B and seed carry = 1.
- Counter width is $clog2(WIDTH). Counter never wraps inside RUN.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, ready=1, busy=0, done=0, result=0, carry_out=0, overflow=0, counter=0, carry=0.
- Reset mid-RUN or in DONE aborts the operation immediately. No done pulse. Outputs take their reset values.
- Latency: start accepted at edge 0. RUN occupies edges 1..WIDTH. done is high in the cycle after edge WIDTH, so the result is visible WIDTH+1 cycles after acceptance. ready returns one cycle after done.
- Throughput: one operation per WIDTH+2 cycles. A start held high continuously gives back-to-back operations with one IDLE cycle between them.
- start and rst_n=0 at the same edge: reset wins.

## Configuration
- SERIAL_ADDER_OVERFLOW_EN defined: a one-bit register captures the carry into the MSB during the last RUN step. overflow = that bit XOR final carry, registered with carry_out.
- SERIAL_ADDER_OVERFLOW_EN undefined: the extra register is omitted and overflow is tied to 0. The port remains so the interface is identical.

## Structure
- Shared package/include holds:
  - state encodings: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - op codes: OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module, serial_fa_cell: combinational 1-bit full adder (A, B, Cin → Sum, Cout), instantiated once.
- The controller holds the FSM, counter, shift registers, and carry/flag registers.

## Test plan
- WIDTH=8, add 0x7F+0x01 → result 0x80, carry_out 0, overflow 1 (0 when macro undefined). done exactly 9 cycles after start is accepted.
- Subtract 0x05−0x07 → result 0xFE, carry_out 0 (borrow), overflow 0. Subtract 0x07−0x05 → 0x02, carry_out 1.
- Add 0xFF+0x01 → result 0x00, carry_out 1, overflow 0. Subtract 0x80−0x01 → 0x7F, overflow 1.
- Pulse start again at cycle 3 of RUN with new operands → ignored. The first result completes unchanged and only one done pulse occurs.
- Drive rst_n=0 in cycle 4 of RUN → next cycle shows IDLE, ready=1, result=0, and no done. A new op afterwards completes correctly.
- Hold start high with randomized a/b/op for 200 ops → every result matches a reference add/sub. Spacing is WIDTH+2 cycles.

Source files
------------

// File: rtl/bit_serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bit_serial_adder_ctrl_pkg
// Shared definitions for the bit-serial add/sub controller: FSM state
// encodings and operation codes.
// No ports (package).
// -----------------------------------------------------------------------------
package bit_serial_adder_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bit_serial_adder_ctrl_serial_fa_cell.sv
// -----------------------------------------------------------------------------
// serial_fa_cell
// Combinational 1-bit full adder, time-shared across all bit positions by
// bit_serial_adder_ctrl.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   sum   : sum bit
//   cout  : carry out
// -----------------------------------------------------------------------------
module serial_fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   always_comb begin
      sum  = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// bit_serial_adder_ctrl
// Adds or subtracts two WIDTH-bit operands one bit per clock, LSB first,
// through a single shared full-adder cell. Operation is accepted with a
// start/ready handshake; done pulses for one cycle when result is valid.
//
// Optional feature: define SERIAL_ADDER_OVERFLOW_EN to build the signed
// overflow flag. Without it, overflow is tied to 0.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   start      : request, sampled only while ready=1
//   op         : 0 = a+b, 1 = a-b
//   a, b       : operands, captured on accepted start
//   ready      : high in IDLE
//   busy       : high in RUN and DONE
//   done       : one-cycle pulse, result valid
//   result     : sum/difference, held until next accepted start
//   carry_out  : final carry from MSB (subtract: 1 = no borrow)
//   overflow   : signed overflow flag
// -----------------------------------------------------------------------------
module bit_serial_adder_ctrl
   import bit_serial_adder_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             carry_out_q, carry_out_d;

   logic fa_sum;
   logic fa_cout;

   serial_fa_cell u_fa (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

`ifdef SERIAL_ADDER_OVERFLOW_EN
   // Carry into the MSB position, i.e. the cell's carry-in on the last step.
   logic msb_cin_q, msb_cin_d;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      carry_d     = carry_q;
      carry_out_d = carry_out_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      msb_cin_d   = msb_cin_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = a;
               // Two's complement subtract: invert b here, seed carry with 1.
               b_d     = (op == OP_SUB) ? ~b : b;
               carry_d = op;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            result_d = {fa_sum, result_q[WIDTH-1:1]};
            carry_d  = fa_cout;
            if (cnt_q == LAST_CNT) begin
               // Counter is left at WIDTH-1 rather than wrapping.
               carry_out_d = fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
               msb_cin_d   = carry_q;
`endif
               state_d     = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
         carry_out_q <= carry_out_d;
      end
   end

`ifdef SERIAL_ADDER_OVERFLOW_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         msb_cin_q <= 1'b0;
      end else begin
         msb_cin_q <= msb_cin_d;
      end
   end

   // Both operands are registers updated on the same edge as carry_out.
   assign overflow = msb_cin_q ^ carry_out_q;
`else
   assign overflow = 1'b0;
`endif

   assign ready     = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign done      = (state_q == ST_DONE);
   assign result    = result_q;
   assign carry_out = carry_out_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_adder_ctrl
// Directed and randomized checks of bit_serial_adder_ctrl at WIDTH=8.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bit_serial_adder_ctrl;

   localparam int unsigned W = 8;

`ifdef SERIAL_ADDER_OVERFLOW_EN
   localparam logic OV_EN = 1'b1;
`else
   localparam logic OV_EN = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;

   int tests;
   int fails;
   int cyc;

   bit_serial_adder_ctrl #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .ready     (ready),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Independent reference: returns {overflow, carry, result}.
   function automatic logic [W+1:0] ref_op(input logic o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
      logic [W-1:0] r;
      logic         c;
      logic         v;
      if (o) begin
         r = x - y;
         c = (x >= y);
         v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end else begin
         {c, r} = {1'b0, x} + {1'b0, y};
         v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      return {v & OV_EN, c, r};
   endfunction

   // Runs one operation from IDLE and checks latency, outputs and done width.
   task automatic run_op(input string name, input logic o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] er,
                         input logic ec, input logic eo);
      int n;
      n = 0;
      while (ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n != W + 1) begin
         fails++;
         $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, W + 1);
      end
      tests++;
      if (result !== er) begin
         fails++;
         $display("FAIL %s result: got %h, expected %h", name, result, er);
      end
      tests++;
      if (carry_out !== ec) begin
         fails++;
         $display("FAIL %s carry_out: got %b, expected %b", name, carry_out, ec);
      end
      tests++;
      if (overflow !== eo) begin
         fails++;
         $display("FAIL %s overflow: got %b, expected %b", name, overflow, eo);
      end
      @(negedge clk);
      tests++;
      if ({done, ready, busy} !== 3'b010) begin
         fails++;
         $display("FAIL %s after_done {done,ready,busy}: got %b, expected 010",
                  name, {done, ready, busy});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;   // reset must win over start
      op    = 1'b0;
      a     = 8'hAA;
      b     = 8'h55;
      repeat (3) @(negedge clk);
      tests++;
      if ({ready, busy, done} !== 3'b100) begin
         fails++;
         $display("FAIL reset {ready,busy,done}: got %b, expected 100", {ready, busy, done});
      end
      tests++;
      if ({result, carry_out, overflow} !== 10'd0) begin
         fails++;
         $display("FAIL reset outputs {result,carry_out,overflow}: got %h, expected 0",
                  {result, carry_out, overflow});
      end
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, OV_EN);
      run_op("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
      run_op("sub_07_05", 1'b1, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0);
      run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
      run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, OV_EN);
   endtask

   task automatic test_ignore_start();
      int pulses;
      logic [W-1:0] r_at_done;
      logic         c_at_done;
      pulses    = 0;
      r_at_done = '0;
      c_at_done = 1'b0;
      start = 1'b1;
      op    = 1'b0;
      a     = 8'h12;
      b     = 8'h34;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      op    = 1'b1;
      a     = 8'hFF;
      b     = 8'h0F;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < W + 8; i++) begin
         if (done === 1'b1) begin
            pulses++;
            r_at_done = result;
            c_at_done = carry_out;
         end
         @(negedge clk);
      end
      tests++;
      if (pulses != 1) begin
         fails++;
         $display("FAIL ignore_start pulses: got %0d, expected 1", pulses);
      end
      tests++;
      if ({r_at_done, c_at_done} !== {8'h46, 1'b0}) begin
         fails++;
         $display("FAIL ignore_start result: got %h/%b, expected 46/0", r_at_done, c_at_done);
      end
   endtask

   task automatic test_reset_mid_run();
      int pulses;
      pulses = 0;
      start = 1'b1;
      op    = 1'b0;
      a     = 8'h55;
      b     = 8'h22;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tests++;
      if ({ready, busy, done} !== 3'b100) begin
         fails++;
         $display("FAIL mid_run_reset {ready,busy,done}: got %b, expected 100",
                  {ready, busy, done});
      end
      tests++;
      if (result !== 8'h00) begin
         fails++;
         $display("FAIL mid_run_reset result: got %h, expected 00", result);
      end
      for (int i = 0; i < W + 4; i++) begin
         if (done === 1'b1) pulses++;
         @(negedge clk);
      end
      tests++;
      if (pulses != 0) begin
         fails++;
         $display("FAIL mid_run_reset stray done: got %0d pulses, expected 0", pulses);
      end
      run_op("after_reset", 1'b0, 8'h55, 8'h22, 8'h77, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [W+1:0] exp;
      int           last_ready;
      int           n;
      last_ready = -1;
      start = 1'b1;
      for (int i = 0; i < 200; i++) begin
         n = 0;
         while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (last_ready >= 0) begin
            tests++;
            if (cyc - last_ready != W + 2) begin
               fails++;
               $display("FAIL b2b spacing op %0d: got %0d, expected %0d",
                        i, cyc - last_ready, W + 2);
            end
         end
         last_ready = cyc;
         op  = 1'($urandom);
         a   = W'($urandom);
         b   = W'($urandom);
         exp = ref_op(op, a, b);
         @(negedge clk);
         n = 0;
         while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
         end
         tests++;
         if ({overflow, carry_out, result} !== exp) begin
            fails++;
            $display("FAIL b2b op %0d {ov,co,result}: got %b_%b_%h, expected %b_%b_%h",
                     i, overflow, carry_out, result, exp[W+1], exp[W], exp[W-1:0]);
         end
      end
      start = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      @(negedge clk);
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_mid_run();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
